// File: rtl/imem_stream_loader_if.sv
// imem_stream_loader_if: byte stream input and instruction-memory write port of the loader
interface imem_stream_loader_if;
    logic        i_byte_vld;
    logic [7:0]  i_byte_data;
    logic        o_byte_rdy;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    modport master (
        input  i_byte_vld, i_byte_data,
        output o_byte_rdy, o_imem_we, o_imem_addr, o_imem_wdata
    );
    modport slave (
        output i_byte_vld, i_byte_data,
        input  o_byte_rdy, o_imem_we, o_imem_addr, o_imem_wdata
    );
endinterface

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: packs a little-endian byte stream into words, writes them to imem, then releases the core
module imem_stream_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 2048
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [15:0]                 i_len_words,
    imem_stream_loader_if.master        bus,
    output logic                        o_core_reset,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_e;
    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] len_q, len_d;
    logic [31:0] word_buf_q, word_buf_d;
    logic        rdy_q, rdy_d, we_q, we_d, core_q, core_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        word_buf_d = word_buf_q;
        case (state_q)
            RECV: begin
                if (bus.i_byte_vld) begin
                    word_buf_d[{byte_cnt_q, 3'b000} +: 8] = bus.i_byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = (byte_cnt_q == 2'd3) ? WRITE : RECV;
                end
            end
            WRITE: begin
                state_d    = (word_idx_q == len_q - 16'd1) ? DONE : RECV;
                word_idx_d = (word_idx_q == len_q - 16'd1) ? word_idx_q : word_idx_q + 16'd1;
            end
            default: begin
                if (i_start) begin
                    len_d      = i_len_words;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 16'd0;
                    state_d    = (i_len_words == 16'd0) ? DONE :
                                 ({16'd0, i_len_words} > DEPTH_WORDS) ? ERR : RECV;
                end
            end
        endcase
        // outputs are decoded from the next state so they leave the flops aligned with it
        rdy_d   = state_d == RECV;
        we_d    = state_d == WRITE;
        addr_d  = we_d ? BASE_ADDR + {14'd0, word_idx_d, 2'b00} : addr_q;
        wdata_d = we_d ? word_buf_d : wdata_q;
        core_d  = state_d == DONE;
        busy_d  = rdy_d || we_d;
        done_d  = state_d == DONE;
        err_d   = state_d == ERR;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 16'd0;
            len_q      <= 16'd0;
            word_buf_q <= 32'd0;
            rdy_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            core_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            word_buf_q <= word_buf_d;
            rdy_q      <= rdy_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_q     <= core_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_byte_rdy   = rdy_q;
    assign bus.o_imem_we    = we_q;
    assign bus.o_imem_addr  = addr_q;
    assign bus.o_imem_wdata = wdata_q;
    assign o_core_reset     = core_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_err            = err_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: randomized loads against a word-list model, with a scoreboard monitor on the imem port
module tb_imem_stream_loader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] len = 16'd0;
    logic        core1, busy1, done1, err1, core2, busy2, done2, err2;
    imem_stream_loader_if bus1();
    imem_stream_loader_if bus2();
    assign bus2.i_byte_vld  = bus1.i_byte_vld;
    assign bus2.i_byte_data = bus1.i_byte_data;

    imem_stream_loader dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_len_words(len), .bus(bus1.master),
        .o_core_reset(core1), .o_busy(busy1), .o_done(done1), .o_err(err1)
    );
    imem_stream_loader #(.BASE_ADDR(32'h100)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_len_words(len), .bus(bus2.master),
        .o_core_reset(core2), .o_busy(busy2), .o_done(done2), .o_err(err2)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
    wr_t exp_q[$];
    int  n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // monitor: pops the scoreboard on every write and tracks byte acceptance for write latency
    initial begin
        wr_t e;
        logic fourth_pend = 1'b0, expect_done = 1'b0;
        int acc_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                fourth_pend = 1'b0;
                expect_done = 1'b0;
                acc_cnt     = 0;
            end else begin
                if (expect_done) begin
                    chk1("done_after_last_write", done1, 1'b1);
                    chk1("core_release_after_last_write", core1, 1'b1);
                    expect_done = 1'b0;
                end
                if (bus1.o_imem_we || fourth_pend) chk1("we_latency", bus1.o_imem_we, fourth_pend);
                if (bus1.o_imem_we) begin
                    if (exp_q.size() == 0) chk1("unexpected_write", bus1.o_imem_we, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", bus1.o_imem_addr, e.addr);
                        chk("wr_data", bus1.o_imem_wdata, e.data);
                        chk("wr_addr_base100", bus2.o_imem_addr, e.addr + 32'h100);
                        chk("wr_data_base100", bus2.o_imem_wdata, e.data);
                        if (exp_q.size() == 0) expect_done = 1'b1;
                    end
                end
                chk1("core_reset_only_in_done", core1, done1);
                chk("base100_status", {26'd0, core2, busy2, done2, err2, bus2.o_byte_rdy, bus2.o_imem_we},
                    {26'd0, core1, busy1, done1, err1, bus1.o_byte_rdy, bus1.o_imem_we});
                fourth_pend = bus1.i_byte_vld && bus1.o_byte_rdy && (acc_cnt % 4 == 3);
                if (bus1.i_byte_vld && bus1.o_byte_rdy) acc_cnt++;
                if (start && !busy1) acc_cnt = 0;
            end
        end
    end

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        len   = n[15:0];
        @(negedge clk);
        start = 1'b0;
        #1;
        chk1("start_rdy", bus1.o_byte_rdy, n > 0 && n <= 2048);
        chk1("start_busy", busy1, n > 0 && n <= 2048);
        chk1("start_done", done1, n == 0);
        chk1("start_err", err1, n > 2048);
        chk1("start_core_reset", core1, n == 0);
    endtask

    task automatic stream(input logic [7:0] b[$], input int gap, input bit poke);
        int i = 0, cyc = 0;
        bit acc;
        while (i < b.size() && cyc < 5000) begin
            @(negedge clk);
            bus1.i_byte_vld  = $urandom_range(0, 99) >= gap;
            bus1.i_byte_data = b[i];
            start = poke && i == 5;
            if (poke && i == 5) len = 16'd9;
            acc = bus1.i_byte_vld && bus1.o_byte_rdy;
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        @(negedge clk);
        bus1.i_byte_vld = 1'b0;
        start = 1'b0;
        if (i < b.size()) chk("stream_bytes_taken", i, b.size());
    endtask

    task automatic wait_end();
        int c = 0;
        while (!(done1 || err1) && c < 1000) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk1("load_completes", done1, 1'b1);
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic load_bytes(input logic [7:0] b[$], input int gap, input bit poke);
        int n = b.size() / 4;
        for (int k = 0; k < n; k++)
            exp_q.push_back('{32'(4 * k), {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]}});
        do_start(n);
        stream(b, gap, poke);
        wait_end();
    endtask

    task automatic load_rand(input int n, input int gap, input bit poke);
        logic [7:0] b[$];
        for (int k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
        load_bytes(b, gap, poke);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_rdy"}, bus1.o_byte_rdy, 1'b0);
        chk1({tag, "_we"}, bus1.o_imem_we, 1'b0);
        chk({tag, "_addr"}, bus1.o_imem_addr, 32'h0);
        chk({tag, "_addr_base100"}, bus2.o_imem_addr, 32'h100);
        chk({tag, "_wdata"}, bus1.o_imem_wdata, 32'h0);
        chk({tag, "_status"}, {28'd0, core1, busy1, done1, err1}, 32'h0);
    endtask

    initial begin
        logic [7:0] prog[$] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                                8'h6F, 8'h00, 8'h00, 8'h00};
        logic [7:0] half[$] = '{8'hAA, 8'hBB};
        bus1.i_byte_vld  = 1'b0;
        bus1.i_byte_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        load_bytes(prog, 0, 1'b0);
        // abort a load with two bytes of the first word taken
        do_start(4);
        stream(half, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_load_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus1.i_byte_vld = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk1("idle_ignores_bytes_rdy", bus1.o_byte_rdy, 1'b0);
        chk1("idle_ignores_bytes_busy", busy1, 1'b0);
        bus1.i_byte_vld = 1'b0;
        do_start(0);
        repeat (5) @(negedge clk);
        #1;
        chk1("zero_len_stays_done", done1, 1'b1);
        do_start(2049);
        repeat (3) @(negedge clk);
        #1;
        chk1("overflow_stays_err", err1, 1'b1);
        chk1("overflow_rdy", bus1.o_byte_rdy, 1'b0);
        load_rand(1, 0, 1'b0);
        load_rand(3, 0, 1'b1);
        for (int r = 0; r < 6; r++) load_rand($urandom_range(1, 6), $urandom_range(0, 60), r == 2);
        load_rand(2048 / 256, 20, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
